// File: rtl/bus_interface.sv
// bus_interface
//   CPU-side register file (pointer + data port) running on cpu_clk, feeding
//   tile / attribute / color RAM write ports that run on clk. A data-port
//   write captures {pointer, data} into a pending register and toggles a
//   request flag. That flag crosses into clk through a 2-flop synchronizer
//   plus an edge detector. Each detected toggle issues exactly one
//   single-cycle RAM write, decoded from the pending pointer.
//
//   Handshake: there is no valid/ready pair. The request toggle acts as the
//   "valid". The pending {pointer, data} payload is held unchanged from the
//   toggle until the next data-port write. The CPU spaces data-port writes
//   at least 4 clk periods apart, so the payload is stable whenever clk
//   samples it. It therefore needs no synchronizer of its own.
module bus_interface (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic [2:0]  addr,
  input  logic        rw,
  input  logic        cs,
  input  logic        cpu_clk,
  output logic        tile_memory_write_enable,
  output logic [10:0] tile_memory_write_addr,
  output logic [7:0]  tile_memory_write_data,
  output logic        attribute_memory_write_enable,
  output logic [11:0] attribute_memory_write_addr,
  output logic [7:0]  attribute_memory_write_data,
  output logic        color_memory_write_enable,
  output logic [3:0]  color_memory_write_addr,
  output logic [7:0]  color_memory_write_data
);

  localparam logic [2:0] REG_PTR_LO = 3'd4;
  localparam logic [2:0] REG_PTR_HI = 3'd5;
  localparam logic [2:0] REG_DATA   = 3'd6;

  localparam logic [15:0] ATTR_BASE  = 16'h0800;
  localparam logic [15:0] COLOR_BASE = 16'h1800;
  localparam logic [15:0] COLOR_END  = 16'h1810;

  // ---------------- cpu_clk domain ----------------
  logic [15:0] r_ptr;
  logic [15:0] r_pend_ptr;
  logic [7:0]  r_pend_data;
  logic        r_req_tgl;

  logic        w_bus_write;

  // Only a selected write cycle touches state; reads and deselected edges are inert.
  assign w_bus_write = (cs == 1'b0) && (rw == 1'b0);

  // Register file: pointer bytes, and the data port that posts a write and bumps the pointer.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= 16'h0000;
      r_pend_ptr  <= 16'h0000;
      r_pend_data <= 8'h00;
      r_req_tgl   <= 1'b0;
    end else if (w_bus_write) begin
      case (addr)
        REG_PTR_LO: r_ptr[7:0]  <= data;
        REG_PTR_HI: r_ptr[15:8] <= data;
        REG_DATA: begin
          r_pend_ptr  <= r_ptr;
          r_pend_data <= data;
          r_req_tgl   <= ~r_req_tgl;
          r_ptr       <= r_ptr + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- clk domain ----------------
  logic r_sync1;
  logic r_sync2;
  logic r_sync_d;
  logic w_req_edge;

  // Two flops bring the toggle into clk. A third flop remembers the last level, for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= r_req_tgl;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Any change of the synchronized level is one new request.
  assign w_req_edge = r_sync2 ^ r_sync_d;

  logic        w_is_tile;
  logic        w_is_attr;
  logic        w_is_color;
  logic [11:0] w_attr_addr;

  // Address-space decode of the pending pointer. Pointers at or above COLOR_END match no region.
  always_comb begin
    w_is_tile   = (r_pend_ptr <  ATTR_BASE);
    w_is_attr   = (r_pend_ptr >= ATTR_BASE)  && (r_pend_ptr < COLOR_BASE);
    w_is_color  = (r_pend_ptr >= COLOR_BASE) && (r_pend_ptr < COLOR_END);
    // The attribute window is exactly 4 KiB, so a 12-bit subtraction is exact.
    w_attr_addr = r_pend_ptr[11:0] - ATTR_BASE[11:0];
  end

  // Tile port: enable pulses for one cycle. Address and data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_memory_write_enable <= 1'b0;
      tile_memory_write_addr   <= 11'h000;
      tile_memory_write_data   <= 8'h00;
    end else begin
      tile_memory_write_enable <= w_req_edge && w_is_tile;
      if (w_req_edge && w_is_tile) begin
        tile_memory_write_addr <= r_pend_ptr[10:0];
        tile_memory_write_data <= r_pend_data;
      end
    end
  end

  // Attribute port: enable pulses for one cycle. Address and data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attribute_memory_write_enable <= 1'b0;
      attribute_memory_write_addr   <= 12'h000;
      attribute_memory_write_data   <= 8'h00;
    end else begin
      attribute_memory_write_enable <= w_req_edge && w_is_attr;
      if (w_req_edge && w_is_attr) begin
        attribute_memory_write_addr <= w_attr_addr;
        attribute_memory_write_data <= r_pend_data;
      end
    end
  end

  // Color port: enable pulses for one cycle. Address and data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_memory_write_enable <= 1'b0;
      color_memory_write_addr   <= 4'h0;
      color_memory_write_data   <= 8'h00;
    end else begin
      color_memory_write_enable <= w_req_edge && w_is_color;
      if (w_req_edge && w_is_color) begin
        color_memory_write_addr <= r_pend_ptr[3:0];
        color_memory_write_data <= r_pend_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_interface.sv
// Directed bench for bus_interface. A monitor logs every RAM write seen on clk.
// Directed steps compare the log against hand-computed expectations.
module tb_bus_interface;

  logic        clk;
  logic        reset;
  logic [7:0]  data;
  logic [2:0]  addr;
  logic        rw;
  logic        cs;
  logic        cpu_clk;
  logic        tile_en;
  logic [10:0] tile_addr;
  logic [7:0]  tile_data;
  logic        attr_en;
  logic [11:0] attr_addr;
  logic [7:0]  attr_data;
  logic        color_en;
  logic [3:0]  color_addr;
  logic [7:0]  color_data;

  localparam logic [1:0] SEL_TILE  = 2'd1;
  localparam logic [1:0] SEL_ATTR  = 2'd2;
  localparam logic [1:0] SEL_COLOR = 2'd3;

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] a;
    logic [7:0]  d;
    int          lat;
  } wr_t;

  wr_t        log_q[$];
  logic [7:0] tile_ram [0:2047];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t_cpu = 0;
  int         mon_n;
  logic       prev_any = 1'b0;

  bus_interface dut (
    .clk                           (clk),
    .reset                         (reset),
    .data                          (data),
    .addr                          (addr),
    .rw                            (rw),
    .cs                            (cs),
    .cpu_clk                       (cpu_clk),
    .tile_memory_write_enable      (tile_en),
    .tile_memory_write_addr        (tile_addr),
    .tile_memory_write_data        (tile_data),
    .attribute_memory_write_enable (attr_en),
    .attribute_memory_write_addr   (attr_addr),
    .attribute_memory_write_data   (attr_data),
    .color_memory_write_enable     (color_en),
    .color_memory_write_addr       (color_addr),
    .color_memory_write_data       (color_data)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cpu_clk is offset so its rising edges never coincide with clk edges.
  initial begin
    cpu_clk = 1'b0;
    #3;
    forever #25 cpu_clk = ~cpu_clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    mon_n = int'(tile_en) + int'(attr_en) + int'(color_en);
    if (mon_n != 0) begin
      wr_t e;
      check("onehot", mon_n, 1);
      check("pulse_width", {31'd0, prev_any}, 0);
      if (tile_en) begin
        e.sel = SEL_TILE; e.a = {1'b0, tile_addr}; e.d = tile_data;
        tile_ram[tile_addr] = tile_data;
      end else if (attr_en) begin
        e.sel = SEL_ATTR; e.a = attr_addr; e.d = attr_data;
      end else begin
        e.sel = SEL_COLOR; e.a = {8'd0, color_addr}; e.d = color_data;
      end
      e.lat = cyc - t_cpu;
      log_q.push_back(e);
    end
    prev_any = (mon_n != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input logic [2:0] a, input logic [7:0] d,
                           input logic r, input logic c);
    @(negedge cpu_clk);
    addr = a; data = d; rw = r; cs = c;
    @(posedge cpu_clk);
    t_cpu = cyc;
    #1;
    cs = 1'b1; rw = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_cycle(a, d, 1'b0, 1'b0);
  endtask

  task automatic expect_write(input string tag, input logic [1:0] sel,
                              input logic [11:0] a, input logic [7:0] d);
    wr_t e;
    repeat (8) @(negedge clk);
    check({tag, "_count"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      e = log_q.pop_front();
      check({tag, "_sel"}, {30'd0, e.sel}, {30'd0, sel});
      check({tag, "_addr"}, {20'd0, e.a}, {20'd0, a});
      check({tag, "_data"}, {24'd0, e.d}, {24'd0, d});
      check({tag, "_latency_2to4"}, {31'd0, (e.lat >= 2 && e.lat <= 4)}, 1);
    end
    log_q.delete();
  endtask

  task automatic expect_none(input string tag);
    repeat (8) @(negedge clk);
    check({tag, "_none"}, log_q.size(), 0);
    log_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; cs = 1'b1; rw = 1'b1; addr = 3'd0; data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_enables", {29'd0, tile_en, attr_en, color_en}, 0);
    check("rst_tile_out", {13'd0, tile_addr, tile_data}, 0);
    check("rst_attr_out", {12'd0, attr_addr, attr_data}, 0);
    check("rst_color_out", {20'd0, color_addr, color_data}, 0);
    reset = 1'b0;

    // tile
    wr(3'd4, 8'h00); wr(3'd5, 8'h01); wr(3'd6, 8'hAA);
    expect_write("tile", SEL_TILE, 12'h100, 8'hAA);
    check("tile_ram_read", {24'd0, tile_ram[11'h100]}, 32'hAA);

    // attribute
    wr(3'd4, 8'h00); wr(3'd5, 8'h09); wr(3'd6, 8'h0E);
    expect_write("attr", SEL_ATTR, 12'h100, 8'h0E);

    // color
    wr(3'd4, 8'h02); wr(3'd5, 8'h18); wr(3'd6, 8'hBE);
    expect_write("color", SEL_COLOR, 12'h002, 8'hBE);

    // auto-increment across the tile/attribute boundary
    wr(3'd4, 8'hFF); wr(3'd5, 8'h07); wr(3'd6, 8'h11);
    expect_write("inc_tile_top", SEL_TILE, 12'h7FF, 8'h11);
    wr(3'd6, 8'h22);
    expect_write("inc_attr_base", SEL_ATTR, 12'h000, 8'h22);

    // top of attribute space
    wr(3'd4, 8'hFF); wr(3'd5, 8'h17); wr(3'd6, 8'h5C);
    expect_write("attr_top", SEL_ATTR, 12'hFFF, 8'h5C);

    // top of color space, then 0x1810 is unmapped but still increments
    wr(3'd4, 8'h0F); wr(3'd5, 8'h18); wr(3'd6, 8'hC3);
    expect_write("color_top", SEL_COLOR, 12'h00F, 8'hC3);
    wr(3'd6, 8'h33);
    expect_none("unmapped_1810");
    wr(3'd5, 8'h00); wr(3'd6, 8'h77);
    expect_write("after_1810_inc", SEL_TILE, 12'h011, 8'h77);

    // ignored cycles: deselected, read, reserved registers
    bus_cycle(3'd6, 8'h01, 1'b0, 1'b1);
    bus_cycle(3'd6, 8'h02, 1'b1, 1'b0);
    bus_cycle(3'd4, 8'hEE, 1'b1, 1'b0);
    bus_cycle(3'd4, 8'hEE, 1'b0, 1'b1);
    wr(3'd7, 8'h03); wr(3'd0, 8'h04); wr(3'd3, 8'h05);
    expect_none("ignored_cycles");
    wr(3'd6, 8'h99);
    expect_write("ptr_untouched", SEL_TILE, 12'h012, 8'h99);

    // 16-bit wrap
    wr(3'd4, 8'hFF); wr(3'd5, 8'hFF); wr(3'd6, 8'h10);
    expect_none("ptr_ffff");
    wr(3'd6, 8'h20);
    expect_write("ptr_wrap", SEL_TILE, 12'h000, 8'h20);

    // reset one clk after a data write discards it and clears the pointer
    wr(3'd4, 8'h34); wr(3'd5, 8'h01); wr(3'd6, 8'h5A);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_enables", {29'd0, tile_en, attr_en, color_en}, 0);
    check("midrst_attr_out", {12'd0, attr_addr, attr_data}, 0);
    check("midrst_color_out", {20'd0, color_addr, color_data}, 0);
    reset = 1'b0;
    expect_none("midrst_discard");
    wr(3'd6, 8'h66);
    expect_write("post_rst", SEL_TILE, 12'h000, 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_interface.md
BUS_INTERFACE -- requirements
Module: bus_interface

Interface
REQ-001 clk  input  1  system clock; all memory write outputs are synchronous to its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset covering both the clk and cpu_clk domains.
REQ-003 data  input  8  CPU data bus; write-only, never driven by the block.
REQ-004 addr  input  3  CPU register select.
REQ-005 rw  input  1  1 = read, 0 = write.
REQ-006 cs  input  1  chip select, active low.
REQ-007 cpu_clk  input  1  CPU bus clock; bus cycle completes on its rising edge; asynchronous to clk.
REQ-008 tile_memory_write_enable / _addr / _data  output  1 / 11 / 8  tile RAM write port.
REQ-009 attribute_memory_write_enable / _addr / _data  output  1 / 12 / 8  attribute RAM write port.
REQ-010 color_memory_write_enable / _addr / _data  output  1 / 4 / 8  color RAM write port.

Function
REQ-011 A bus write SHALL be a cpu_clk rising edge with cs=0 and rw=0; all other edges are ignored.
REQ-012 Register map SHALL be:
- 4 = pointer low byte
- 5 = pointer high byte
- 6 = data port
- 0-3 and 7 = reserved; writes ignored.
REQ-013 Writes to registers 4 and 5 SHALL load the corresponding byte of a 16-bit VRAM pointer held in the cpu_clk domain.
REQ-014 A write to register 6 SHALL, on the same cpu_clk edge:
- capture {pointer, data} into a pending register;
- toggle a request flag;
- post-increment the pointer by 1 (16-bit, 0xFFFF wraps to 0x0000).
REQ-015 The request flag SHALL cross into the clk domain through a 2-flop synchronizer plus edge detector; each toggle SHALL produce exactly one write.
REQ-016 Decoding of the pending pointer P SHALL be:
- 0x0000-0x07FF: tile, addr = P[10:0]
- 0x0800-0x17FF: attribute, addr = P - 0x0800
- 0x1800-0x180F: color, addr = P[3:0]
- 0x1810-0xFFFF: no write issued.
REQ-017 Per write, exactly one matching write_enable SHALL be high for exactly one clk cycle; its addr/data outputs are valid in that cycle.
REQ-018 Write latency SHALL be 2-4 clk cycles from the cpu_clk rising edge.
REQ-019 Consecutive data-port writes SHALL be at least 4 clk periods apart; pointer writes carry no spacing constraint.
REQ-020 Write_enable outputs SHALL be low whenever no write is being issued; addr/data outputs hold their last value.
REQ-021 rw=1 cycles SHALL change no state.
REQ-022 The memory ports SHALL be write-only; reads are served by the renderer via separate RAM read ports.

Reset
REQ-023 While reset is high, the following SHALL be cleared and all write enables SHALL be 0:
- pointer = 0x0000
- pending register = 0
- request flag and synchronizer flops = 0
- all addr/data outputs = 0
REQ-024 A pending write not yet issued when reset asserts SHALL be discarded.
REQ-025 After reset deasserts, the first bus write SHALL be accepted normally.

Verification
REQ-026 Tile write: regs 4=0x00, 5=0x01, 6=0xAA -> tile write addr 0x100, data 0xAA; RAM read at 0x100 returns 0xAA.
REQ-027 Attribute write: regs 4=0x00, 5=0x09, 6=0x0E -> attribute write addr 0x100, data 0x0E; no tile or color enable.
REQ-028 Color write: regs 4=0x02, 5=0x18, 6=0xBE -> color write addr 0x2, data 0xBE.
REQ-029 Auto-increment: pointer 0x07FF, then data 0x11 and 0x22 -> tile write 0x7FF=0x11, then attribute write 0x000=0x22.
REQ-030 Ignored cycles: pointer 0x1810 with data write, any write with cs=1, or any rw=1 cycle -> no write enable asserted; the 0x1810 write still increments the pointer to 0x1811.
REQ-031 Reset mid-operation: assert reset one clk after a data write -> no write issued, pointer reads back as 0x0000 via a subsequent data write landing at tile 0x000.
